rle_flash_fetch: RTL and testbench

RLE_FLASH_FETCH -- requirements
Module: rle_flash_fetch

---
 rtl/rle_pkg.sv | 23 ++
 rtl/rle_word_fifo.sv | 66 ++++++
 rtl/rle_flash_fetch.sv | 197 +++++++++++++++++++
 tb/tb_rle_flash_fetch.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rle_pkg.sv
// rle_pkg: shared definitions for the RLE flash fetch block.
//   - fetch_state_t : serial read FSM states
//   - CMD_QUAD_READ : Quad Output Fast Read opcode
//   - ADDR_BITS / DUMMY_CYCLES : read header geometry
//   - RUN_W / COLOUR_W / WORD_W : RLE word layout {run_length, colour}
package rle_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA
    } fetch_state_t;

    localparam logic [7:0] CMD_QUAD_READ = 8'h6B;
    localparam int         ADDR_BITS     = 24;
    localparam int         DUMMY_CYCLES  = 8;
    localparam int         RUN_W         = 10;
    localparam int         COLOUR_W      = 6;
    localparam int         WORD_W        = RUN_W + COLOUR_W;

endpackage

// File: rtl/rle_word_fifo.sv
// rle_word_fifo: synchronous prefetch FIFO for 16-bit RLE words.
// Ports:
//   clk, rstn       clock, synchronous active-low reset
//   i_push/i_wdata  write a word (accepted when not full, or full with pop)
//   i_pop           drop the head word (ignored when empty)
//   i_flush         discard all contents, wins over push/pop
//   o_rdata         head word, forced to 0 while empty
//   o_full / o_almost_full (>= DEPTH-1) / o_empty
module rle_word_fifo
    import rle_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_push,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic [WORD_W-1:0] o_rdata,
    output logic              o_full,
    output logic              o_almost_full,
    output logic              o_empty
);

    localparam int            PW         = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT   = (PW+1)'(DEPTH);
    localparam logic [PW:0]   ALMOST_CNT = (PW+1)'(DEPTH - 1);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW:0]       r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_do_pop      = i_pop && (r_count != '0);
    assign w_do_push     = i_push && ((r_count != FULL_CNT) || w_do_pop);
    assign o_empty       = (r_count == '0);
    assign o_full        = (r_count == FULL_CNT);
    assign o_almost_full = (r_count >= ALMOST_CNT);
    assign o_rdata       = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push && rstn && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rle_flash_fetch.sv
// rle_flash_fetch: streams RLE words {run_length[9:0], colour[5:0]} out of a
// quad-SPI flash using Quad Output Fast Read, buffered in a small FIFO.
// Ports:
//   clk, rstn                     clock, synchronous active-low reset
//   read_next                     pop FIFO head (ignored while data_ready low)
//   stop_data                     abort and hold fetching off
//   save_addr/load_addr/clear_addr  head address save / restore / reset to BASE_ADDR
//   data_ready, data              FIFO non-empty, FIFO head word
//   spi_cs_n, spi_sck             flash select (active-low), flash clock (clk/2)
//   spi_d_out, spi_d_oe, spi_d_in IO0..IO3 drive, enable, sample
// Build option RLE_FETCH_IN_REG_EN: spi_d_in goes through one clk register and
// each nibble is consumed one clk after the rising SCK edge.
//
// state    | meaning
// ST_IDLE  | CS high, waiting for empty FIFO, no abort and CS gap elapsed
// ST_CMD   | shifting 0x6B out on IO0
// ST_ADDR  | shifting 24-bit head address out on IO0
// ST_DUMMY | 8 dummy SCK cycles, IO released
// ST_DATA  | sampling nibbles; SCK parks low at a word boundary when FIFO full
module rle_flash_fetch
    import rle_pkg::*;
#(
    parameter logic [23:0] BASE_ADDR  = 24'h000000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        read_next,
    input  logic        stop_data,
    input  logic        save_addr,
    input  logic        load_addr,
    input  logic        clear_addr,
    output logic        data_ready,
    output logic [15:0] data,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic [3:0]  spi_d_out,
    output logic [3:0]  spi_d_oe,
    input  logic [3:0]  spi_d_in
);

    fetch_state_t      r_state;
    logic              r_cs_n;
    logic              r_sck;
    logic              r_oe;
    logic [31:0]       r_tx;
    logic [4:0]        r_cnt;
    logic [1:0]        r_nib;
    logic [11:0]       r_shift;
    logic [WORD_W-1:0] r_word;
    logic              r_push;
    logic              r_gap;
    logic [23:0]       r_head_addr;
    logic [23:0]       r_save_addr;

    logic              w_abort;
    logic              w_pop;
    logic              w_stall;
    logic              w_sample;
    logic              w_take;
    logic [3:0]        w_nib;
    logic [23:0]       w_head_next;
    logic              w_fifo_full;
    logic              w_fifo_afull;
    logic              w_fifo_empty;
    logic [WORD_W-1:0] w_fifo_rdata;

    assign w_abort = stop_data || clear_addr || load_addr;
    assign w_pop   = read_next && !w_fifo_empty;

    // A new word may only start if it has somewhere to land; a word still
    // waiting in r_push counts as already occupying a slot.
    assign w_stall  = (r_nib == 2'd3) && (w_fifo_full || (w_fifo_afull && r_push));
    assign w_sample = (r_state == ST_DATA) && !r_sck && !w_stall;

`ifdef RLE_FETCH_IN_REG_EN
    logic [3:0] r_din;
    logic       r_take;

    always_ff @(posedge clk) begin
        r_din <= spi_d_in;
        if (!rstn || w_abort) r_take <= 1'b0;
        else                  r_take <= w_sample;
    end

    assign w_take = r_take;
    assign w_nib  = r_din;
`else
    assign w_take = w_sample;
    assign w_nib  = spi_d_in;
`endif

    always_ff @(posedge clk) begin
        if (!rstn || w_abort) begin
            r_state <= ST_IDLE;
            r_cs_n  <= 1'b1;
            r_sck   <= 1'b0;
            r_oe    <= 1'b0;
            r_tx    <= '0;
            r_cnt   <= '0;
            r_nib   <= 2'd3;
            r_shift <= '0;
            r_word  <= '0;
            r_push  <= 1'b0;
            r_gap   <= 1'b1;
        end else begin
            r_push <= 1'b0;
            if (w_take) begin
                r_shift <= {r_shift[7:0], w_nib};
                r_nib   <= r_nib - 2'd1;
                if (r_nib == 2'd0) begin
                    r_word <= {r_shift, w_nib};
                    r_push <= 1'b1;
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (r_gap) begin
                        r_gap <= 1'b0;
                    end else if (w_fifo_empty && !stop_data) begin
                        r_state <= ST_CMD;
                        r_cs_n  <= 1'b0;
                        r_oe    <= 1'b1;
                        r_tx    <= {CMD_QUAD_READ, r_head_addr};
                        r_cnt   <= 5'd7;
                    end
                end
                ST_CMD, ST_ADDR, ST_DUMMY: begin
                    r_sck <= ~r_sck;
                    // Falling SCK: present the next header bit (zeros shift in,
                    // so IO0 is already 0 by the time the header ends).
                    if (r_sck) begin
                        r_tx <= {r_tx[30:0], 1'b0};
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 5'd1;
                        end else if (r_state == ST_CMD) begin
                            r_state <= ST_ADDR;
                            r_cnt   <= 5'(ADDR_BITS - 1);
                        end else if (r_state == ST_ADDR) begin
                            r_state <= ST_DUMMY;
                            r_cnt   <= 5'(DUMMY_CYCLES - 1);
                            r_oe    <= 1'b0;
                        end else begin
                            r_state <= ST_DATA;
                            r_nib   <= 2'd3;
                        end
                    end
                end
                ST_DATA: begin
                    if (r_sck)         r_sck <= 1'b0;
                    else if (!w_stall) r_sck <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_head_next = r_head_addr;
        if (clear_addr)     w_head_next = BASE_ADDR;
        else if (load_addr) w_head_next = r_save_addr;
        else if (w_pop)     w_head_next = r_head_addr + 24'd2;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_head_addr <= BASE_ADDR;
            r_save_addr <= BASE_ADDR;
        end else begin
            r_head_addr <= w_head_next;
            if (save_addr) r_save_addr <= w_head_next;
        end
    end

    rle_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rstn          (rstn),
        .i_push        (r_push),
        .i_wdata       (r_word),
        .i_pop         (read_next),
        .i_flush       (w_abort),
        .o_rdata       (w_fifo_rdata),
        .o_full        (w_fifo_full),
        .o_almost_full (w_fifo_afull),
        .o_empty       (w_fifo_empty)
    );

    assign data_ready = !w_fifo_empty;
    assign data       = w_fifo_rdata;
    assign spi_cs_n   = r_cs_n;
    assign spi_sck    = r_sck;
    assign spi_d_out  = {3'b000, r_tx[31]};
    assign spi_d_oe   = {3'b000, r_oe};

endmodule

// File: tb/tb_rle_flash_fetch.sv
// tb_rle_flash_fetch: bench for rle_flash_fetch with a behavioural quad-SPI
// flash model and scoreboards for popped words and read transactions.
module tb_rle_flash_fetch;

`ifdef RLE_FETCH_IN_REG_EN
    localparam int EXP_LAT = 89;
`else
    localparam int EXP_LAT = 88;
`endif

    logic        clk        = 1'b0;
    logic        rstn       = 1'b0;
    logic        read_next  = 1'b0;
    logic        stop_data  = 1'b0;
    logic        save_addr  = 1'b0;
    logic        load_addr  = 1'b0;
    logic        clear_addr = 1'b0;
    logic        data_ready;
    logic [15:0] data;
    logic        spi_cs_n;
    logic        spi_sck;
    logic [3:0]  spi_d_out;
    logic [3:0]  spi_d_oe;
    logic [3:0]  flash_io   = 4'h0;

    always #5 clk = ~clk;

    rle_flash_fetch #(
        .BASE_ADDR  (24'h000000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .read_next  (read_next),
        .stop_data  (stop_data),
        .save_addr  (save_addr),
        .load_addr  (load_addr),
        .clear_addr (clear_addr),
        .data_ready (data_ready),
        .data       (data),
        .spi_cs_n   (spi_cs_n),
        .spi_sck    (spi_sck),
        .spi_d_out  (spi_d_out),
        .spi_d_oe   (spi_d_oe),
        .spi_d_in   (flash_io)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [15:0] exp_words [$];
    logic [23:0] exp_txn   [$];
    logic [23:0] exp_head  = 24'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] fbyte(input logic [23:0] a);
        case (a)
            24'h000000: return 8'h12;
            24'h000001: return 8'h34;
            24'h000002: return 8'hAB;
            24'h000003: return 8'hCD;
            default:    return (a[7:0] * 8'd13) + 8'h29;
        endcase
    endfunction

    function automatic logic [15:0] fword(input logic [23:0] a);
        return {fbyte(a), fbyte(a + 24'd1)};
    endfunction

    // Flash model: header on IO0 sampled on rising SCK, nibbles driven after
    // each falling SCK once 40 header/dummy clocks have gone by.
    int          rise_cnt = 0;
    logic [31:0] hdr      = '0;
    logic [23:0] txn_addr = '0;

    always @(negedge spi_cs_n) begin
        rise_cnt = 0;
        hdr      = '0;
        flash_io = 4'h0;
    end

    always @(posedge spi_cs_n) flash_io = 4'h0;

    always @(posedge spi_sck) begin
        if (!spi_cs_n) begin
            rise_cnt++;
            if (rise_cnt <= 32) begin
                check("hdr oe", spi_d_oe, 4'b0001);
                hdr = {hdr[30:0], spi_d_out[0]};
                if (rise_cnt == 32) begin
                    txn_addr = hdr[23:0];
                    if (exp_txn.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL txn unexpected addr got=%0h", hdr[23:0]);
                    end else begin
                        check("txn cmd", hdr[31:24], 8'h6B);
                        check("txn addr", hdr[23:0], exp_txn.pop_front());
                    end
                end
            end else if (rise_cnt <= 40) begin
                check("dummy oe", spi_d_oe, 4'b0000);
            end
        end
    end

    always @(negedge spi_sck) begin
        if (!spi_cs_n && rise_cnt >= 40) begin
            int          idx;
            logic [7:0]  b;
            idx      = rise_cnt - 40;
            b        = fbyte(txn_addr + 24'(idx / 2));
            flash_io = (idx % 2 == 0) ? b[7:4] : b[3:0];
        end
    end

    // Scoreboard monitor: every accepted pop is compared to the queued word.
    always @(negedge clk) begin
        if (rstn && read_next && data_ready && !clear_addr && !load_addr && !stop_data) begin
            if (exp_words.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop unexpected got=%0h", data);
            end else begin
                check("pop word", data, exp_words.pop_front());
            end
        end
    end

    task automatic pop_word(input logic with_save);
        int n;
        n = 0;
        @(posedge clk); #2;
        while (!data_ready && n < 400) begin
            @(posedge clk); #2;
            n++;
        end
        if (!data_ready) begin
            check("pop wait data_ready", data_ready, 1);
            return;
        end
        exp_words.push_back(fword(exp_head));
        exp_head  = exp_head + 24'd2;
        read_next = 1'b1;
        save_addr = with_save;
        @(posedge clk); #2;
        read_next = 1'b0;
        save_addr = 1'b0;
    endtask

    task automatic pulse_ctl(input logic c, input logic l, input logic s);
        @(posedge clk); #2;
        clear_addr = c;
        load_addr  = l;
        save_addr  = s;
        @(posedge clk); #2;
        clear_addr = 1'b0;
        load_addr  = 1'b0;
        save_addr  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t0;
        int hi;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst cs_n", spi_cs_n, 1);
        check("rst sck", spi_sck, 0);
        check("rst d_out", spi_d_out, 0);
        check("rst d_oe", spi_d_oe, 0);
        check("rst data_ready", data_ready, 0);
        check("rst data", data, 0);
        check("rst head_addr", dut.r_head_addr, 24'h0);
        check("rst save_addr", dut.r_save_addr, 24'h0);

        // First transaction from 0 and its latency
        exp_txn.push_back(24'h0);
        @(posedge clk); #2;
        rstn = 1'b1;
        n = 0;
        while (spi_cs_n && n < 50) begin @(negedge clk); n++; end
        check("cs fall", spi_cs_n, 0);
        t0 = cyc;
        n = 0;
        while (!data_ready && n < 200) begin @(negedge clk); n++; end
        check("first data_ready", data_ready, 1);
        check("first latency window",
              ((cyc - t0) >= EXP_LAT - 1) && ((cyc - t0) <= EXP_LAT + 1), 1);
        check("first word", data, 16'h1234);
        pop_word(1'b0);
        n = 0;
        @(negedge clk);
        while (!data_ready && n < 50) begin @(negedge clk); n++; end
        check("head after pop", data, 16'hABCD);

        // Fill and stall
        repeat (200) @(posedge clk);
        @(negedge clk);
        check("stall fifo count", dut.u_fifo.r_count, 4);
        check("stall cs_n", spi_cs_n, 0);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (spi_sck) hi++;
        end
        check("stall sck high samples", hi, 0);
        for (int i = 0; i < 5; i++) pop_word(1'b0);
        @(negedge clk);
        check("head after 6 pops", dut.r_head_addr, exp_head);

        // Save / clear / load
        exp_txn.push_back(24'h0);
        exp_head = 24'h0;
        pulse_ctl(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) pop_word(1'b0);
        pulse_ctl(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("saved after 3 pops", dut.r_save_addr, 24'h000006);
        exp_txn.push_back(24'h0);
        exp_head = 24'h0;
        pulse_ctl(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("head after clear", dut.r_head_addr, 24'h0);
        pop_word(1'b0);
        exp_txn.push_back(24'h000006);
        exp_head = 24'h000006;
        pulse_ctl(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("load cs_n", spi_cs_n, 1);
        check("load data_ready", data_ready, 0);
        check("head after load", dut.r_head_addr, 24'h000006);
        hi = 0;
        n = 0;
        while (spi_cs_n && n < 20) begin hi++; @(negedge clk); n++; end
        check("cs high gap >= 2", hi >= 2, 1);
        pop_word(1'b0);

        // stop_data mid-DATA
        repeat (3) @(posedge clk);
        #2;
        exp_txn.push_back(exp_head);
        stop_data = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("stop cs_n", spi_cs_n, 1);
            check("stop sck", spi_sck, 0);
            check("stop data_ready", data_ready, 0);
        end
        @(posedge clk); #2;
        stop_data = 1'b0;
        pop_word(1'b0);

        // clear wins over load; save sees same-cycle increment
        exp_txn.push_back(24'h0);
        exp_head = 24'h0;
        pulse_ctl(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("clear over load head", dut.r_head_addr, 24'h0);
        for (int i = 0; i < 8; i++) pop_word(1'b0);
        @(negedge clk);
        check("head at 0x10", dut.r_head_addr, 24'h000010);
        pop_word(1'b1);
        @(negedge clk);
        check("save with read_next", dut.r_save_addr, 24'h000012);
        check("head after save pop", dut.r_head_addr, 24'h000012);

        // Reset mid-transaction
        @(posedge clk); #2;
        exp_txn.push_back(24'h0);
        exp_head = 24'h0;
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst cs_n", spi_cs_n, 1);
        check("midrst sck", spi_sck, 0);
        check("midrst data_ready", data_ready, 0);
        check("midrst head", dut.r_head_addr, 24'h0);
        check("midrst saved", dut.r_save_addr, 24'h0);
        @(posedge clk); #2;
        rstn = 1'b1;
        pop_word(1'b0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("word queue drained", exp_words.size(), 0);
        check("txn queue drained", exp_txn.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
